// File: rtl/hash_req_arbiter_pkg.sv
// Shared constants, tag type and round-robin pick helper for the hash request arbiter.
package hash_req_arbiter_pkg;

  localparam int HASH_LAT = 7;
  localparam int KEY_W    = 48;
  localparam int HASH_W   = 32;
  localparam int MAX_REQ  = 8;
  localparam int ID_W     = $clog2(MAX_REQ);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  // First requesting index found scanning upward from last+1, wrapping at n.
  // Callers must qualify the result with |req.
  function automatic logic [ID_W-1:0] rr_next(input logic [MAX_REQ-1:0] req,
                                              input logic [ID_W-1:0]    last,
                                              input int                 n);
    logic [ID_W-1:0] idx;
    rr_next = last;
    for (int k = n; k >= 1; k--) begin
      idx = ID_W'((int'(last) + k) % n);
      if (req[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/hash_req_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves only on advance.
module rr_arbiter
  import hash_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  logic [ID_W-1:0]    last_grant_q;
  logic [ID_W-1:0]    pick;
  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    pick                   = rr_next(req_ext, last_grant_q, NUM_REQ);
    grant                  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = (|req) && (pick == ID_W'(i));
    end
  end

  // Reset to the highest index so requester 0 wins the first search.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else if (advance) begin
      last_grant_q <= pick;
    end
  end

endmodule

// File: rtl/hash_req_arbiter.sv
// Shares one fixed-latency hash core among NUM_REQ requesters; tags each key so the
// result returns to its owner. Handshake: a key transfers on a cycle where req_valid[i] & req_ready[i].
module hash_req_arbiter
  import hash_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LAT     = HASH_LAT
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*KEY_W-1:0] req_key,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [HASH_W-1:0]        resp_hash,
  output logic [KEY_W-1:0]         hash_in_data,
  input  logic [HASH_W-1:0]        hash_out_data,
  output logic                     hash_rst,
  input  logic                     cfg_pause,
  output logic                     idle,
  output logic [31:0]              issue_cnt
);

  logic [NUM_REQ-1:0] req_gated;
  logic [NUM_REQ-1:0] grant;
  logic               handshake;
  logic [ID_W-1:0]    grant_id;
  logic [KEY_W-1:0]   grant_key;
  logic               issue_vld;
  logic [ID_W-1:0]    issue_id;
  logic [31:0]        issue_cnt_q;
  tag_t               tag_q [LAT];
  logic [1:0]         rst_sync_q;
  logic               any_tag_vld;

  // Grants are withheld while paused and while the core is still in reset.
  assign req_gated = req_valid & {NUM_REQ{~cfg_pause & ~hash_rst}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req_gated),
    .advance (handshake),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign handshake = |grant;

  always_comb begin
    grant_id  = '0;
    grant_key = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id  = ID_W'(i);
        grant_key = req_key[i*KEY_W +: KEY_W];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hash_in_data <= '0;
      issue_vld    <= 1'b0;
      issue_id     <= '0;
      issue_cnt_q  <= '0;
    end else begin
      hash_in_data <= handshake ? grant_key : '0;
      issue_vld    <= handshake;
      issue_id     <= grant_id;
      if (handshake) issue_cnt_q <= issue_cnt_q + 32'd1;
    end
  end

  assign issue_cnt = issue_cnt_q;

  // Tag stage LAT-1 lines up with hash_out_data; it never stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_t'{vld: issue_vld, id: issue_id};
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    resp_valid  = '0;
    any_tag_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = tag_q[LAT-1].vld && (tag_q[LAT-1].id == ID_W'(i));
    end
    for (int i = 0; i < LAT; i++) begin
      any_tag_vld = any_tag_vld | tag_q[i].vld;
    end
  end

  assign resp_hash = hash_out_data;
  assign idle      = ~issue_vld & ~any_tag_vld;

  // Core reset asserts with resetn and releases on the 2nd clock edge after it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign hash_rst = ~rst_sync_q[1];

endmodule
